// File: rtl/tetris_keys_pkg.sv
// Scan-code constants, parser/owner encodings and key index map shared by the
// PS/2 game-key front end.
package tetris_keys_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_P     = 8'h4D;

  // Bit positions within keys_held and the internal pulse vector.
  localparam int unsigned KEY_LEFT  = 0;
  localparam int unsigned KEY_RIGHT = 1;
  localparam int unsigned KEY_UP    = 2;
  localparam int unsigned KEY_DOWN  = 3;
  localparam int unsigned KEY_SPACE = 4;
  localparam int unsigned KEY_P     = 5;
  localparam int unsigned NUM_KEYS  = 6;

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } parse_state_e;

  typedef enum logic [1:0] {
    OwnNone,
    OwnLeft,
    OwnRight
  } h_owner_e;

  // One-hot key for a completed code; keypad arrows (non-extended) map to nothing.
  function automatic logic [NUM_KEYS-1:0] key_decode(input logic [7:0] code, input logic ext);
    logic [NUM_KEYS-1:0] k;
    k = '0;
    if (ext) begin
      case (code)
        SC_LEFT:  k[KEY_LEFT]  = 1'b1;
        SC_RIGHT: k[KEY_RIGHT] = 1'b1;
        SC_UP:    k[KEY_UP]    = 1'b1;
        SC_DOWN:  k[KEY_DOWN]  = 1'b1;
        default:  k = '0;
      endcase
    end else begin
      case (code)
        SC_SPACE: k[KEY_SPACE] = 1'b1;
        SC_P:     k[KEY_P]     = 1'b1;
        default:  k = '0;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/ps2_game_keys_if.sv
// Byte-stream input and command/status output bundle between the PS/2 receiver,
// the key front end and the game control FSM.
interface ps2_game_keys_if;
  import tetris_keys_pkg::*;

  logic [7:0]          scan_code;
  logic                scan_code_valid;
  logic                clear_held;
  logic                move_left;
  logic                move_right;
  logic                rotate;
  logic                soft_drop;
  logic                hard_drop;
  logic                pause_toggle;
  logic [NUM_KEYS-1:0] keys_held;

  modport master (
    output scan_code, scan_code_valid, clear_held,
    input  move_left, move_right, rotate, soft_drop, hard_drop, pause_toggle, keys_held
  );

  modport slave (
    input  scan_code, scan_code_valid, clear_held,
    output move_left, move_right, rotate, soft_drop, hard_drop, pause_toggle, keys_held
  );

endinterface

// File: rtl/key_repeat_timer.sv
// Down-counter for key auto-repeat: expire is high while running at zero; the
// owner is expected to reload on expire.
module key_repeat_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             run,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = run && (cnt_q == '0);

endmodule

// File: rtl/ps2_game_keys.sv
// PS/2 Set-2 byte stream to one-cycle Tetris command pulses, with held-key
// tracking and DAS/ARR horizontal repeat plus soft-drop repeat.
module ps2_game_keys
  import tetris_keys_pkg::*;
#(
  parameter int unsigned DAS_CYCLES = 8500000,
  parameter int unsigned ARR_CYCLES = 2500000,
  parameter int unsigned SD_CYCLES  = 2500000,
  parameter int unsigned CNT_W      = 24
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  ps2_game_keys_if.slave  kb
);

  localparam logic [CNT_W-1:0] DAS_LOAD = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARR_LOAD = CNT_W'(ARR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SD_LOAD  = CNT_W'(SD_CYCLES - 1);

  parse_state_e        state_q, state_d;
  h_owner_e            owner_q, owner_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] pulse_q, pulse_d;
  logic [NUM_KEYS-1:0] make_raw, brk_raw, make_key, brk_key, new_make;

  logic             h_load, h_run, h_expire;
  logic [CNT_W-1:0] h_val;
  logic             sd_load, sd_run, sd_expire;
  logic [CNT_W-1:0] sd_val;

  // Parser: only advances on strobe cycles.
  always_comb begin
    state_d  = state_q;
    make_raw = '0;
    brk_raw  = '0;
    if (kb.scan_code_valid) begin
      unique case (state_q)
        StIdle: begin
          if (kb.scan_code == SC_EXT) begin
            state_d = StExt;
          end else if (kb.scan_code == SC_BRK) begin
            state_d = StBrk;
          end else begin
            make_raw = key_decode(kb.scan_code, 1'b0);
          end
        end
        StExt: begin
          if (kb.scan_code == SC_BRK) begin
            state_d = StExtBrk;
          end else if (kb.scan_code != SC_EXT) begin
            make_raw = key_decode(kb.scan_code, 1'b1);
            state_d  = StIdle;
          end
        end
        StBrk: begin
          brk_raw = key_decode(kb.scan_code, 1'b0);
          state_d = StIdle;
        end
        StExtBrk: begin
          brk_raw = key_decode(kb.scan_code, 1'b1);
          state_d = StIdle;
        end
      endcase
    end
  end

  // clear_held suppresses any make completed in the same cycle.
  always_comb begin
    make_key = kb.clear_held ? '0 : make_raw;
    brk_key  = kb.clear_held ? '0 : brk_raw;
    new_make = make_key & ~held_q;
    held_d   = kb.clear_held ? '0 : ((held_q & ~brk_key) | make_key);
  end

  assign h_run  = (owner_q != OwnNone);
  assign sd_run = held_q[KEY_DOWN];

  always_comb begin
    pulse_d          = '0;
    pulse_d[KEY_UP]    = new_make[KEY_UP];
    pulse_d[KEY_SPACE] = new_make[KEY_SPACE];
    pulse_d[KEY_P]     = new_make[KEY_P];

    sd_load = 1'b0;
    sd_val  = SD_LOAD;
    if (kb.clear_held) begin
      sd_load = 1'b1;
      sd_val  = '0;
    end else if (new_make[KEY_DOWN] || (sd_expire && !brk_key[KEY_DOWN])) begin
      pulse_d[KEY_DOWN] = 1'b1;
      sd_load           = 1'b1;
    end

    owner_d = owner_q;
    h_load  = 1'b0;
    h_val   = DAS_LOAD;
    if (kb.clear_held) begin
      owner_d = OwnNone;
      h_load  = 1'b1;
      h_val   = '0;
    end else if (new_make[KEY_LEFT]) begin
      owner_d           = OwnLeft;
      pulse_d[KEY_LEFT] = 1'b1;
      h_load            = 1'b1;
    end else if (new_make[KEY_RIGHT]) begin
      owner_d            = OwnRight;
      pulse_d[KEY_RIGHT] = 1'b1;
      h_load             = 1'b1;
    end else if ((owner_q == OwnLeft) && brk_key[KEY_LEFT]) begin
      // Releasing the owner hands repeat to the other key if it is still down.
      if (held_q[KEY_RIGHT]) begin
        owner_d            = OwnRight;
        pulse_d[KEY_RIGHT] = 1'b1;
        h_load             = 1'b1;
      end else begin
        owner_d = OwnNone;
      end
    end else if ((owner_q == OwnRight) && brk_key[KEY_RIGHT]) begin
      if (held_q[KEY_LEFT]) begin
        owner_d           = OwnLeft;
        pulse_d[KEY_LEFT] = 1'b1;
        h_load            = 1'b1;
      end else begin
        owner_d = OwnNone;
      end
    end else if (h_expire) begin
      h_load = 1'b1;
      h_val  = ARR_LOAD;
      if (owner_q == OwnLeft) begin
        pulse_d[KEY_LEFT] = 1'b1;
      end else begin
        pulse_d[KEY_RIGHT] = 1'b1;
      end
    end
  end

  key_repeat_timer #(
    .CNT_W(CNT_W)
  ) u_h_timer (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .load      (h_load),
    .load_value(h_val),
    .run       (h_run),
    .expire    (h_expire)
  );

  key_repeat_timer #(
    .CNT_W(CNT_W)
  ) u_sd_timer (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .load      (sd_load),
    .load_value(sd_val),
    .run       (sd_run),
    .expire    (sd_expire)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= OwnNone;
      held_q  <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      held_q  <= held_d;
      pulse_q <= pulse_d;
    end
  end

  assign kb.move_left    = pulse_q[KEY_LEFT];
  assign kb.move_right   = pulse_q[KEY_RIGHT];
  assign kb.rotate       = pulse_q[KEY_UP];
  assign kb.soft_drop    = pulse_q[KEY_DOWN];
  assign kb.hard_drop    = pulse_q[KEY_SPACE];
  assign kb.pause_toggle = pulse_q[KEY_P];
  assign kb.keys_held    = held_q;

endmodule
